// File: rtl/rom_loader_if.sv
// Memory write port of the boot loader: word address/data with a valid/ready handshake.
interface rom_loader_if;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_ready;

  modport master (
    output mem_address,
    output mem_write_data,
    output mem_write_enable,
    input  mem_ready
  );

  modport slave (
    input  mem_address,
    input  mem_write_data,
    input  mem_write_enable,
    output mem_ready
  );
endinterface

// File: rtl/rom_loader.sv
// Boot loader: streams bytes from a combinational ROM, packs them little-endian
// into 32-bit words and writes them to memory until the ROM flags its last byte.
module rom_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_BYTES = 65536
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic [31:0]  rom_address,
  input  logic [7:0]   rom_byte,
  input  logic         rom_done,
  rom_loader_if.master mem,
  output logic         busy,
  output logic         finished,
  output logic         error,
  output logic [31:0]  word_count
);

  localparam logic [31:0] BYTE_LIMIT = 32'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t      state;
  logic [31:0] buffer;
  logic [31:0] merged;
  logic        last_byte;

  // Current buffer with the ROM byte dropped into its lane.
  always_comb begin
    merged = buffer;
    merged[{rom_address[1:0], 3'b000} +: 8] = rom_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                <= IDLE;
      rom_address          <= '0;
      buffer               <= '0;
      last_byte            <= 1'b0;
      mem.mem_address      <= '0;
      mem.mem_write_data   <= '0;
      mem.mem_write_enable <= 1'b0;
      busy                 <= 1'b0;
      finished             <= 1'b0;
      error                <= 1'b0;
      word_count           <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= FETCH;
            rom_address <= '0;
            buffer      <= '0;
            last_byte   <= 1'b0;
            word_count  <= '0;
            finished    <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b1;
          end
        end
        FETCH: begin
          // Overrun guard: byte number MAX_BYTES is never latched.
          if (rom_address >= BYTE_LIMIT) begin
            state    <= DONE;
            error    <= 1'b1;
            finished <= 1'b1;
            busy     <= 1'b0;
          end else begin
            buffer    <= merged;
            last_byte <= rom_done;
            if (rom_address[1:0] == 2'd3 || rom_done) begin
              state                <= WRITE;
              mem.mem_write_enable <= 1'b1;
              mem.mem_write_data   <= merged;
              mem.mem_address      <= BASE_ADDR + {word_count[29:0], 2'b00};
            end else begin
              rom_address <= rom_address + 32'd1;
            end
          end
        end
        WRITE: begin
          if (mem.mem_ready) begin
            mem.mem_write_enable <= 1'b0;
            word_count           <= word_count + 32'd1;
            if (last_byte) begin
              state    <= DONE;
              finished <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state       <= FETCH;
              buffer      <= '0;
              rom_address <= rom_address + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: a reference model of the packed image feeds
// expected writes into queues that per-DUT monitors drain on each accepted write.
module tb_rom_loader;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] BASE2 = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start, start2;
  logic [31:0] rom_address, rom_address2;
  logic [7:0]  rom_byte, rom_byte2;
  logic        rom_done, rom_done2;
  logic        busy, finished, error, busy2, finished2, error2;
  logic [31:0] word_count, word_count2;

  logic [7:0]  img [256];
  int          done_idx;
  int          ready_mode;

  wr_t         exp_q[$];
  wr_t         exp_q2[$];
  logic [31:0] cap_addr [1024];
  logic [31:0] cap_data [1024];
  int          cap_n  = 0;
  int          cap2_n = 0;
  int          n_cmp  = 0;
  int          n_bad  = 0;

  logic        held = 1'b0;
  logic [31:0] h_addr, h_data, h_rom;

  rom_loader_if mif ();
  rom_loader_if mif2 ();

  assign rom_byte  = img[rom_address[7:0]];
  assign rom_done  = (done_idx >= 0) && (rom_address == 32'(done_idx));
  assign rom_byte2 = img[rom_address2[7:0]];

  rom_loader #(.BASE_ADDR(BASE), .MAX_BYTES(65536)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rom_address(rom_address), .rom_byte(rom_byte), .rom_done(rom_done),
    .mem(mif.master),
    .busy(busy), .finished(finished), .error(error), .word_count(word_count)
  );

  rom_loader #(.BASE_ADDR(BASE2), .MAX_BYTES(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .rom_address(rom_address2), .rom_byte(rom_byte2), .rom_done(rom_done2),
    .mem(mif2.master),
    .busy(busy2), .finished(finished2), .error(error2), .word_count(word_count2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference model: word k = ROM bytes 4k..4k+3 little-endian, missing lanes zero.
  task automatic push_model(input int didx, input int max_bytes, input logic [31:0] base,
                            input bit to2, output int words, output int nbytes);
    wr_t w;
    if (didx >= 0 && didx < max_bytes) begin
      nbytes = didx + 1;
      words  = (nbytes + 3) / 4;
    end else begin
      nbytes = max_bytes;
      words  = max_bytes / 4;
    end
    for (int k = 0; k < words; k++) begin
      w.addr = base + 32'(4 * k);
      w.data = '0;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < nbytes) w.data[8*b +: 8] = img[4*k+b];
      if (to2) exp_q2.push_back(w);
      else     exp_q.push_back(w);
    end
  endtask

  // Scoreboard monitor for the main DUT, plus stall stability tracking.
  always @(negedge clk) begin
    if (reset_n && mif.mem_write_enable) begin
      if (held) begin
        chk("stall_addr_stable", mif.mem_address, h_addr);
        chk("stall_data_stable", mif.mem_write_data, h_data);
        chk("stall_rom_frozen", rom_address, h_rom);
      end
      if (mif.mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("write_without_expectation", exp_q.size(), 1);
        end else begin
          chk("wr_addr", mif.mem_address, exp_q[0].addr);
          chk("wr_data", mif.mem_write_data, exp_q[0].data);
          exp_q.delete(0);
        end
        cap_addr[cap_n[9:0]] <= mif.mem_address;
        cap_data[cap_n[9:0]] <= mif.mem_write_data;
        cap_n <= cap_n + 1;
        held  <= 1'b0;
      end else begin
        held   <= 1'b1;
        h_addr <= mif.mem_address;
        h_data <= mif.mem_write_data;
        h_rom  <= rom_address;
      end
    end else begin
      held <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n && mif2.mem_write_enable && mif2.mem_ready) begin
      if (exp_q2.size() == 0) begin
        chk("guard_write_without_expectation", exp_q2.size(), 1);
      end else begin
        chk("guard_wr_addr", mif2.mem_address, exp_q2[0].addr);
        chk("guard_wr_data", mif2.mem_write_data, exp_q2[0].data);
        exp_q2.delete(0);
      end
      cap2_n <= cap2_n + 1;
    end
  end

  task automatic wait_finish(output int n, output int stalls);
    bit r;
    int stall_left;
    stall_left = 3;
    n = 0;
    stalls = 0;
    while (n < 3000) begin
      r = 1'b1;
      if (ready_mode == 1) r = ($urandom_range(0, 2) != 0);
      if (ready_mode == 2 && mif.mem_write_enable && word_count == 32'd2 && stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end
      if (mif.mem_write_enable && !r) stalls++;
      mif.mem_ready = r;
      @(posedge clk);
      n++;
      #1;
      if (finished) break;
    end
    chk("finish_within_budget", finished, 1);
  endtask

  task automatic load(input bit hold, output int n, output int stalls);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    chk("start_rom_address", rom_address, 0);
    chk("start_flags", {busy, finished, error}, 3'b100);
    chk("start_word_count", word_count, 0);
    wait_finish(n, stalls);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rom_address"}, rom_address, 0);
    chk({nm, "_mem_address"}, mif.mem_address, 0);
    chk({nm, "_mem_data"}, mif.mem_write_data, 0);
    chk({nm, "_flags"}, {mif.mem_write_enable, busy, finished, error}, 0);
    chk({nm, "_word_count"}, word_count, 0);
  endtask

  task automatic full_image();
    logic [31:0] w0, w5, w57;
    w0 = 32'h0000_0001;
    w5 = 32'h0007_A120;
    w57 = 32'h0000_000D;
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    for (int b = 0; b < 4; b++) begin
      img[b]       = w0[8*b +: 8];
      img[20 + b]  = w5[8*b +: 8];
      img[228 + b] = w57[8*b +: 8];
    end
    done_idx = 231;
  endtask

  initial begin
    int n, s, words, nbytes, c0, c2;
    reset_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    rom_done2 = 1'b0;
    mif.mem_ready = 1'b0;
    mif2.mem_ready = 1'b1;
    ready_mode = 0;
    done_idx = -1;
    for (int i = 0; i < 256; i++) img[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset_dut2", {rom_address2, word_count2, busy2, finished2, error2, mif2.mem_write_enable}, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Full generated image, memory always ready.
    full_image();
    push_model(done_idx, 65536, BASE, 1'b0, words, nbytes);
    c0 = cap_n;
    load(1'b0, n, s);
    chk("full_finish_edge", n, 290);
    chk("full_word_count", word_count, 58);
    chk("full_done_flags", {busy, finished, error}, 3'b010);
    chk("full_write_count", cap_n - c0, 58);
    chk("full_first_word", {cap_addr[c0], cap_data[c0]}, {BASE, 32'h0000_0001});
    chk("full_word5", {cap_addr[c0+5], cap_data[c0+5]}, {BASE + 32'd20, 32'h0007_A120});
    chk("full_last_word", {cap_addr[c0+57], cap_data[c0+57]}, {BASE + 32'd228, 32'h0000_000D});

    // Three stall cycles on word 2.
    ready_mode = 2;
    push_model(done_idx, 65536, BASE, 1'b0, words, nbytes);
    load(1'b0, n, s);
    chk("stall_cycles_applied", s, 3);
    chk("stall_finish_edge", n, 293);
    chk("stall_word_count", word_count, 58);

    // Partial final word.
    ready_mode = 0;
    for (int i = 0; i < 6; i++) img[i] = 8'(i + 1);
    done_idx = 5;
    push_model(done_idx, 65536, BASE, 1'b0, words, nbytes);
    c0 = cap_n;
    load(1'b0, n, s);
    chk("partial_finish_edge", n, 8);
    chk("partial_write_count", cap_n - c0, 2);
    chk("partial_word0", {cap_addr[c0], cap_data[c0]}, {BASE, 32'h0403_0201});
    chk("partial_word1", {cap_addr[c0+1], cap_data[c0+1]}, {BASE + 32'd4, 32'h0000_0605});

    // Random images under random backpressure.
    ready_mode = 1;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
      done_idx = int'($urandom_range(0, 99));
      push_model(done_idx, 65536, BASE, 1'b0, words, nbytes);
      load(1'b0, n, s);
      chk("random_finish_edge", n, nbytes + words + s);
      chk("random_word_count", word_count, words);
    end

    // Reset during the WRITE of word 3, then reload from scratch.
    ready_mode = 0;
    full_image();
    push_model(done_idx, 65536, BASE, 1'b0, words, nbytes);
    start = 1'b1;
    mif.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mif.mem_write_enable && word_count == 32'd3) break;
      @(posedge clk);
      #1;
    end
    chk("reach_word3_write", {mif.mem_write_enable, word_count}, {1'b1, 32'd3});
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("midop_reset");
    exp_q.delete();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push_model(done_idx, 65536, BASE, 1'b0, words, nbytes);
    load(1'b0, n, s);
    chk("reload_finish_edge", n, 290);
    chk("reload_word_count", word_count, 58);

    // Start held high across a load and into DONE.
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    done_idx = 9;
    push_model(done_idx, 65536, BASE, 1'b0, words, nbytes);
    push_model(done_idx, 65536, BASE, 1'b0, words, nbytes);
    load(1'b1, n, s);
    chk("hold_finish_edge", n, 13);
    chk("hold_word_count", word_count, 3);
    @(posedge clk);
    #1;
    chk("hold_restart_word_count", word_count, 0);
    chk("hold_restart_flags", {busy, finished}, 2'b10);
    start = 1'b0;
    wait_finish(n, s);
    chk("hold_second_finish_edge", n, 13);
    chk("hold_second_word_count", word_count, 3);

    // Byte-count guard on the MAX_BYTES=16 instance.
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    push_model(-1, 16, BASE2, 1'b1, words, nbytes);
    c2 = cap2_n;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n = 0;
    while (n < 200 && !finished2) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("guard_finish_edge", n, 21);
    chk("guard_flags", {error2, finished2, busy2}, 3'b110);
    chk("guard_rom_address", rom_address2, 16);
    chk("guard_word_count", word_count2, 4);
    repeat (5) @(posedge clk);
    #1;
    chk("guard_write_count", cap2_n - c2, 4);
    chk("guard_no_fifth_write", mif2.mem_write_enable, 0);

    chk("main_queue_drained", exp_q.size(), 0);
    chk("guard_queue_drained", exp_q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
